fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 9'h000, PC value loaded on reset.
REQ-002 Parameter ADDR_W, default 9, byte-address width of instruction memory.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fetch_en  input  1  1 = fetch proceeds; 0 = halt fetching.
REQ-006 stall  input  1  1 = hold PC and IF/ID register (downstream busy).
REQ-007 redirect_valid  input  1  taken branch/jump from execute this cycle.
REQ-008 redirect_pc  input  ADDR_W  branch/jump target byte address.
REQ-009 imem_ra  output  ADDR_W  read address to instruction memory, equals current PC combinationally.
REQ-010 imem_rd  input  32  instruction word returned combinationally for imem_ra.
REQ-011 id_valid  output  1  IF/ID register holds a real instruction.
REQ-012 id_pc  output  ADDR_W  PC of instruction in IF/ID.
REQ-013 id_instr  output  32  instruction in IF/ID; NOP 32'h00000013 when id_valid=0.
REQ-014 misalign_err  output  1  sticky flag: a redirect target had nonzero bits [1:0].
REQ-015 perf_fetched, perf_bubbles  output  32 each  performance counters (see Configuration).

Function
REQ-016 FSM states S_HALT and S_RUN; S_HALT->S_RUN when fetch_en=1; S_RUN->S_HALT when fetch_en=0 and redirect_valid=0.
REQ-017 In S_HALT: PC holds; on each edge with stall=0, IF/ID loads bubble (id_valid=0, id_instr=NOP).
REQ-018 In S_RUN, edge with stall=0, redirect_valid=0: id_instr<=imem_rd, id_pc<=PC, id_valid<=1, PC<=PC+4 (fetch latency 1 cycle).
REQ-019 PC+4 wraps modulo 2^ADDR_W: 9'h1FC -> 9'h000, no error.
REQ-020 stall=1, redirect_valid=0: PC, id_valid, id_pc, id_instr all hold.
REQ-021 redirect_valid=1 in any state: PC<={redirect_pc[ADDR_W-1:2],2'b00}, IF/ID loads bubble; redirect overrides stall and fetch_en.
REQ-022 Redirect with redirect_pc[1:0]!=0 sets misalign_err; it remains set until reset.
REQ-023 Instruction at redirect target appears in IF/ID two edges after redirect edge (one bubble cycle) if stall=0.

Reset
REQ-024 reset=1 at an edge: PC<=RESET_PC, state<=S_HALT, id_valid<=0, id_pc<=0, id_instr<=NOP, misalign_err<=0, counters<=0.
REQ-025 reset has priority over redirect_valid, stall and fetch_en, including mid-stall or mid-redirect.

Configuration
REQ-026 Macro FETCH_PERF_EN defined: perf_fetched increments on each edge loading id_valid=1; perf_bubbles increments on each edge loading a bubble; both wrap at 2^32.
REQ-027 FETCH_PERF_EN undefined: counter logic absent; perf_fetched and perf_bubbles tied to 0.

Structure
REQ-028 Package fetch_pkg holds ADDR_W default, INSTR_W=32, NOP_INSTR=32'h00000013, and fetch state enum.
REQ-029 IF/ID register (load, bubble, hold) implemented as sub-module if_id_reg; PC/FSM/counters in fetch_unit.

Verification
REQ-030 Reset then fetch_en=1, stall=0, memory word at addr N = N: id_pc sequence 0,4,8,... with id_instr matching, first valid 1 edge after enabling.
REQ-031 Stall asserted 3 cycles at PC=8: imem_ra stays 8, id_pc stays 4, id_valid stays 1; resumes with id_pc=8.
REQ-032 redirect_valid=1, redirect_pc=9'h040 while stall=1: next edge id_valid=0, imem_ra=9'h040; following edge id_pc=9'h040, id_valid=1.
REQ-033 Run from PC=9'h1F8: id_pc 9'h1F8, 9'h1FC, 9'h000; misalign_err stays 0.
REQ-034 redirect_pc=9'h046: imem_ra=9'h044, misalign_err=1, held after; reset mid-run clears it, imem_ra=RESET_PC, id_valid=0.
REQ-035 With FETCH_PERF_EN: 10 fetches, 1 redirect -> perf_fetched=10, perf_bubbles=1; without macro both read 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
package fetch_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int INSTR_W    = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        S_HALT = 1'b0,
        S_RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// Instruction memory read port and IF/ID stage outputs of the fetch unit.
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);

    logic [ADDR_W-1:0]  imem_ra;
    logic [INSTR_W-1:0] imem_rd;
    logic               id_valid;
    logic [ADDR_W-1:0]  id_pc;
    logic [INSTR_W-1:0] id_instr;

    modport master (
        output imem_ra,
        input  imem_rd,
        output id_valid,
        output id_pc,
        output id_instr
    );

    modport slave (
        input  imem_ra,
        output imem_rd,
        input  id_valid,
        input  id_pc,
        input  id_instr
    );

endinterface

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register: reset, bubble insertion, load, or hold.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               bubble,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic [INSTR_W-1:0] instr_in,
    output logic               valid_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [INSTR_W-1:0] instr_out
);

    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    // Bubble wins over load so a redirect always squashes the wrong-path fetch.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (bubble) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = pc_in;
            instr_d = instr_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_out = valid_q;
    assign pc_out    = pc_q;
    assign instr_out = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, halt/run FSM, redirect handling and IF/ID register.
// Define FETCH_PERF_EN to build the fetched/bubble performance counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    fetch_if.master           bus,
    output logic              misalign_err,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_bubbles
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              misalign_q, misalign_d;
    logic              load, bubble;

    logic               id_valid;
    logic [ADDR_W-1:0]  id_pc;
    logic [INSTR_W-1:0] id_instr;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_HALT: if (fetch_en) state_d = S_RUN;
            S_RUN:  if (!fetch_en && !redirect_valid) state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // A redirect overrides both stall and halt; the target is word-aligned by dropping bits [1:0].
    always_comb begin
        pc_d       = pc_q;
        misalign_d = misalign_q;
        load       = 1'b0;
        bubble     = 1'b0;
        if (redirect_valid) begin
            pc_d   = {redirect_pc[ADDR_W-1:2], 2'b00};
            bubble = 1'b1;
            if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
        end else if (!stall) begin
            if (state_q == S_RUN) begin
                load = 1'b1;
                pc_d = pc_q + ADDR_W'(4);
            end else begin
                bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_HALT;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    if_id_reg #(.ADDR_W(ADDR_W)) u_if_id_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .bubble    (bubble),
        .pc_in     (pc_q),
        .instr_in  (bus.imem_rd),
        .valid_out (id_valid),
        .pc_out    (id_pc),
        .instr_out (id_instr)
    );

    assign bus.imem_ra  = pc_q;
    assign bus.id_valid = id_valid;
    assign bus.id_pc    = id_pc;
    assign bus.id_instr = id_instr;
    assign misalign_err = misalign_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] bubbles_q, bubbles_d;

    always_comb begin
        fetched_d = fetched_q + {31'd0, load};
        bubbles_d = bubbles_q + {31'd0, bubble};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q <= '0;
            bubbles_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            bubbles_q <= bubbles_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`else
    assign perf_fetched = 32'd0;
    assign perf_bubbles = 32'd0;
`endif

endmodule
